// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_pkg
// Brief    : Shared AXI4-lite response codes and register-index decode.
// Revision : 1.0  initial release
// ============================================================================
package axi_lite_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;
    localparam axi_resp_t RESP_DECERR = 2'b11;

    localparam int ADDR_LSB = 2;

    typedef enum logic [1:0] {
        REG_RW   = 2'd0,
        REG_RO   = 2'd1,
        REG_NONE = 2'd2
    } reg_kind_t;

    function automatic reg_kind_t decode_idx(
        input logic [31:0] idx,
        input int unsigned num_rw,
        input int unsigned num_ro
    );
        if (idx < num_rw)
            return REG_RW;
        else if (idx < num_rw + num_ro)
            return REG_RO;
        else
            return REG_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_wr_capture.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_wr_capture
// Brief    : Independent AW/W holding registers, READY generation and commit.
// Revision : 1.0  initial release
// ============================================================================
module axi_lite_wr_capture #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     i_awaddr,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_wstrb,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    input  logic                  i_resp_pending,
    output logic [ADDR_W-1:0]     o_addr,
    output logic [DATA_W-1:0]     o_data,
    output logic [DATA_W/8-1:0]   o_strb,
    output logic                  o_commit
);

    logic                r_aw_held;
    logic                r_w_held;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W/8-1:0] r_strb;

    // Both halves must already be held, so commit lands one edge after the later handshake.
    assign o_commit  = r_aw_held && r_w_held;
    assign o_awready = !rst && !r_aw_held && !i_resp_pending;
    assign o_wready  = !rst && !r_w_held  && !i_resp_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_strb    <= '0;
        end else if (o_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
        end else begin
            if (i_awvalid && o_awready) begin
                r_aw_held <= 1'b1;
                r_addr    <= i_awaddr;
            end
            if (i_wvalid && o_wready) begin
                r_w_held <= 1'b1;
                r_data   <= i_wdata;
                r_strb   <= i_wstrb;
            end
        end
    end

    assign o_addr = r_addr;
    assign o_data = r_data;
    assign o_strb = r_strb;

endmodule
`default_nettype wire

// File: rtl/axi4_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_regs
// Brief    : AXI4-lite register bank: RW control words out, RO status words in.
// Revision : 1.0  initial release
// ============================================================================
module axi4_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            NUM_RW             = 8,
    parameter int                            NUM_RO             = 8,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] RW_RESET_VAL       = '0
) (
    input  logic                                 S_AXI_ACLK,
    input  logic                                 S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                           S_AXI_AWPROT,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                           S_AXI_ARPROT,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0] ctrl_o,
    output logic [NUM_RW-1:0]                    wr_pulse_o,
    input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0] status_i,
    output logic [NUM_RO-1:0]                    rd_pulse_o
);

    localparam int c_aw = C_S_AXI_ADDR_WIDTH;
    localparam int c_dw = C_S_AXI_DATA_WIDTH;

    logic [c_aw-1:0]   w_wr_addr;
    logic [c_dw-1:0]   w_wr_data;
    logic [c_dw/8-1:0] w_wr_strb;
    logic              w_commit;
    logic [31:0]       w_wr_idx;
    reg_kind_t         w_wr_kind;
    logic [31:0]       w_rd_idx;
    reg_kind_t         w_rd_kind;
    logic              w_ar_hs;
    logic [c_dw-1:0]   w_rd_ctrl;
    logic [c_dw-1:0]   w_rd_status;
    logic [NUM_RO-1:0] w_rd_ro_hit;
    logic              w_unused;

    logic [c_dw-1:0]   r_ctrl [NUM_RW];
    logic [NUM_RW-1:0] r_wr_pulse;
    logic              r_bvalid;
    axi_resp_t         r_bresp;
    logic              r_rvalid;
    axi_resp_t         r_rresp;
    logic [c_dw-1:0]   r_rdata;
    logic [NUM_RO-1:0] r_rd_pulse;

    axi_lite_wr_capture #(
        .ADDR_W (c_aw),
        .DATA_W (c_dw)
    ) u_wr_capture (
        .clk            (S_AXI_ACLK),
        .rst            (S_AXI_ARESET),
        .i_awaddr       (S_AXI_AWADDR),
        .i_awvalid      (S_AXI_AWVALID),
        .o_awready      (S_AXI_AWREADY),
        .i_wdata        (S_AXI_WDATA),
        .i_wstrb        (S_AXI_WSTRB),
        .i_wvalid       (S_AXI_WVALID),
        .o_wready       (S_AXI_WREADY),
        .i_resp_pending (r_bvalid),
        .o_addr         (w_wr_addr),
        .o_data         (w_wr_data),
        .o_strb         (w_wr_strb),
        .o_commit       (w_commit)
    );

    assign w_wr_idx  = 32'(w_wr_addr[c_aw-1:ADDR_LSB]);
    assign w_wr_kind = decode_idx(w_wr_idx, NUM_RW, NUM_RO);
    assign w_rd_idx  = 32'(S_AXI_ARADDR[c_aw-1:ADDR_LSB]);
    assign w_rd_kind = decode_idx(w_rd_idx, NUM_RW, NUM_RO);
    assign w_ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_ARADDR[ADDR_LSB-1:0], w_wr_addr[ADDR_LSB-1:0]};

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NUM_RW; i++)
                r_ctrl[i] <= RW_RESET_VAL;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit && w_wr_kind == REG_RW) begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (w_wr_idx == i) begin
                        for (int b = 0; b < c_dw/8; b++)
                            if (w_wr_strb[b])
                                r_ctrl[i][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                        r_wr_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            case (w_wr_kind)
                REG_RW:  r_bresp <= RESP_OKAY;
                REG_RO:  r_bresp <= RESP_SLVERR;
                default: r_bresp <= RESP_DECERR;
            endcase
        end else if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
        end
    end

    always_comb begin
        w_rd_ctrl   = '0;
        w_rd_status = '0;
        w_rd_ro_hit = '0;
        for (int i = 0; i < NUM_RW; i++)
            if (w_rd_idx == i)
                w_rd_ctrl = r_ctrl[i];
        for (int j = 0; j < NUM_RO; j++) begin
            if (w_rd_idx == NUM_RW + j) begin
                w_rd_status    = status_i[j*c_dw +: c_dw];
                w_rd_ro_hit[j] = 1'b1;
            end
        end
    end

    // RW reads see the pre-commit value because r_ctrl updates on the same edge.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
            r_rd_pulse <= '0;
        end else begin
            r_rd_pulse <= '0;
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                case (w_rd_kind)
                    REG_RW: begin
                        r_rdata <= w_rd_ctrl;
                        r_rresp <= RESP_OKAY;
                    end
                    REG_RO: begin
                        r_rdata    <= w_rd_status;
                        r_rresp    <= RESP_OKAY;
                        r_rd_pulse <= w_rd_ro_hit;
                    end
                    default: begin
                        r_rdata <= '0;
                        r_rresp <= RESP_DECERR;
                    end
                endcase
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl_out
        assign ctrl_o[g*c_dw +: c_dw] = r_ctrl[g];
    end

    assign S_AXI_ARREADY = !S_AXI_ARESET && !r_rvalid;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;
    assign wr_pulse_o    = r_wr_pulse;
    assign rd_pulse_o    = r_rd_pulse;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_slave_regs
// Brief    : Directed vector bench for the AXI4-lite register bank.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi4_lite_slave_regs;

    localparam int          NRW     = 4;
    localparam int          NRO     = 2;
    localparam logic [31:0] RST_VAL = 32'hCAFE_0000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [31:0]    awaddr = '0, wdata = '0, araddr = '0;
    logic [2:0]     awprot = 3'd0, arprot = 3'd0;
    logic           awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic           arvalid = 1'b0, rready = 1'b0;
    logic [3:0]     wstrb = '0;
    logic           awready, wready, bvalid, arready, rvalid;
    logic [1:0]     bresp, rresp;
    logic [31:0]    rdata;
    logic [NRW*32-1:0] ctrl;
    logic [NRW-1:0] wr_pulse;
    logic [NRO*32-1:0] status = {32'h00C0_FFEE, 32'hA5A5_0000};
    logic [NRO-1:0] rd_pulse;

    int total = 0;
    int passed = 0;
    int cnt2 = 0;
    logic [31:0] model [NRW];

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_pulse[2]) cnt2++;

    axi4_lite_slave_regs #(
        .C_S_AXI_ADDR_WIDTH (32),
        .C_S_AXI_DATA_WIDTH (32),
        .NUM_RW             (NRW),
        .NUM_RO             (NRO),
        .RW_RESET_VAL       (RST_VAL)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .ctrl_o        (ctrl),
        .wr_pulse_o    (wr_pulse),
        .status_i      (status),
        .rd_pulse_o    (rd_pulse)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        else
            passed++;
    endtask

    task automatic timeout(input string name);
        total++;
        $display("FAIL %s: actual=timeout required=handshake", name);
    endtask

    task automatic check_ctrl(input string name);
        for (int i = 0; i < NRW; i++)
            check($sformatf("%s ctrl%0d", name, i), ctrl[i*32 +: 32], model[i]);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat,
                            output logic [3:0] wp, output logic [3:0] wp_next);
        int n;
        logic aw_hs, w_hs;
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            n++;
        end
        if (awvalid || wvalid) timeout("aw_w_handshake");
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bvalid) timeout("bvalid_wait");
        resp = bresp; wp = wr_pulse;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        wp_next = wr_pulse;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output int lat, output logic [1:0] rp, output logic [1:0] rp_next);
        int n;
        logic hs;
        araddr = a; arvalid = 1'b1; n = 0; hs = 1'b0;
        while (!hs && n < 20) begin
            hs = arready;
            @(posedge clk); #1;
            n++;
        end
        arvalid = 1'b0;
        if (!hs) timeout("ar_handshake");
        lat = 0;
        while (!rvalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rvalid) timeout("rvalid_wait");
        d = rdata; resp = rresp; rp = rd_pulse;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        rp_next = rd_pulse;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [3:0]  pulse;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        logic [3:0]  wp, wp_next;
        logic [1:0]  rp, rp_next;
        int          lat;
        logic [31:0] idx;

        //           wr    addr    data          strb   resp   rdata         pulse
        vecs[0]  = '{1'b1, 32'h0C, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        4'b1000};
        vecs[1]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 4'b0000};
        vecs[2]  = '{1'b1, 32'h04, 32'h11223344, 4'hF, 2'b00, 32'h0,        4'b0010};
        vecs[3]  = '{1'b1, 32'h04, 32'hAABBCCDD, 4'h5, 2'b00, 32'h0,        4'b0010};
        vecs[4]  = '{1'b0, 32'h04, 32'h0,        4'h0, 2'b00, 32'h11BB33DD, 4'b0000};
        vecs[5]  = '{1'b1, 32'h10, 32'h12345678, 4'hF, 2'b10, 32'h0,        4'b0000};
        vecs[6]  = '{1'b0, 32'h14, 32'h0,        4'h0, 2'b00, 32'h00C0FFEE, 4'b0010};
        vecs[7]  = '{1'b0, 32'h10, 32'h0,        4'h0, 2'b00, 32'hA5A50000, 4'b0001};
        vecs[8]  = '{1'b0, 32'h18, 32'h0,        4'h0, 2'b11, 32'h0,        4'b0000};
        vecs[9]  = '{1'b1, 32'h40, 32'h0,        4'hF, 2'b11, 32'h0,        4'b0000};
        vecs[10] = '{1'b0, 32'h00, 32'h0,        4'h0, 2'b00, 32'hCAFE0000, 4'b0000};
        vecs[11] = '{1'b1, 32'h00, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0,        4'b0001};
        vecs[12] = '{1'b0, 32'h00, 32'h0,        4'h0, 2'b00, 32'hCAFE0000, 4'b0000};
        vecs[13] = '{1'b1, 32'h0B, 32'h0000FFFF, 4'h3, 2'b00, 32'h0,        4'b0100};
        vecs[14] = '{1'b0, 32'h08, 32'h0,        4'h0, 2'b00, 32'hCAFEFFFF, 4'b0000};
        vecs[15] = '{1'b1, 32'h14, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0,        4'b0000};
        vecs[16] = '{1'b1, 32'h1A, 32'h00000001, 4'hF, 2'b11, 32'h0,        4'b0000};

        for (int i = 0; i < NRW; i++) model[i] = RST_VAL;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst awready", awready, 0);
        check("rst wready", wready, 0);
        check("rst arready", arready, 0);
        check("rst bvalid", bvalid, 0);
        check("rst rvalid", rvalid, 0);
        check("rst bresp", bresp, 0);
        check("rst rresp", rresp, 0);
        check("rst rdata", rdata, 0);
        check("rst wr_pulse", wr_pulse, 0);
        check("rst rd_pulse", rd_pulse, 0);
        check_ctrl("rst");
        rst = 1'b0;
        #1;
        check("post-rst awready", awready, 1);
        check("post-rst arready", arready, 1);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat, wp, wp_next);
                check($sformatf("v%0d bresp", i), resp, vecs[i].resp);
                check($sformatf("v%0d b latency", i), lat, 1);
                check($sformatf("v%0d wr_pulse", i), wp, vecs[i].pulse);
                check($sformatf("v%0d wr_pulse drop", i), wp_next, 0);
                check($sformatf("v%0d bvalid drop", i), bvalid, 0);
                idx = vecs[i].addr >> 2;
                if (idx < NRW)
                    for (int b = 0; b < 4; b++)
                        if (vecs[i].strb[b]) model[idx][b*8 +: 8] = vecs[i].data[b*8 +: 8];
                check_ctrl($sformatf("v%0d", i));
            end else begin
                do_read(vecs[i].addr, d, resp, lat, rp, rp_next);
                check($sformatf("v%0d rresp", i), resp, vecs[i].resp);
                check($sformatf("v%0d rdata", i), d, vecs[i].rdata);
                check($sformatf("v%0d r latency", i), lat, 0);
                check($sformatf("v%0d rd_pulse", i), rp, vecs[i].pulse);
                check($sformatf("v%0d rd_pulse drop", i), rp_next, 0);
                check($sformatf("v%0d rvalid drop", i), rvalid, 0);
            end
        end

        // W three cycles ahead of AW, BREADY held off for two cycles
        cnt2 = 0;
        wdata = 32'h55667788; wstrb = 4'hF; wvalid = 1'b1;
        check("t3 wready idle", wready, 1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        check("t3 wready held", wready, 0);
        repeat (2) @(posedge clk);
        #1;
        check("t3 no early bvalid", bvalid, 0);
        awaddr = 32'h08; awvalid = 1'b1;
        check("t3 awready", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("t3 bvalid not yet", bvalid, 0);
        @(posedge clk); #1;
        check("t3 bvalid", bvalid, 1);
        awaddr = 32'h00; awvalid = 1'b1; wdata = 32'hFFFFFFFF; wvalid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t3 awready blocked %0d", k), awready, 0);
            check($sformatf("t3 wready blocked %0d", k), wready, 0);
            check($sformatf("t3 bvalid hold %0d", k), bvalid, 1);
            check($sformatf("t3 bresp hold %0d", k), bresp, 2'b00);
            @(posedge clk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("t3 bvalid drop", bvalid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t3 no second commit", bvalid, 0);
        check("t3 single pulse", cnt2, 1);
        model[2] = 32'h55667788;
        check_ctrl("t3");

        // Reset with AW held and W never sent
        awaddr = 32'h00; awvalid = 1'b1;
        check("t6 awready", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6 awready in rst", awready, 0);
        check("t6 wready in rst", wready, 0);
        repeat (2) @(posedge clk);
        #1;
        check("t6 bvalid in rst", bvalid, 0);
        for (int i = 0; i < NRW; i++) model[i] = RST_VAL;
        check_ctrl("t6 rst");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6 bvalid after rst", bvalid, 0);
        check("t6 awready after rst", awready, 1);
        check("t6 wready after rst", wready, 1);
        do_write(32'h00, 32'h01020304, 4'hF, resp, lat, wp, wp_next);
        check("t6 fresh bresp", resp, 2'b00);
        check("t6 fresh latency", lat, 1);
        check("t6 fresh wr_pulse", wp, 4'b0001);
        do_read(32'h00, d, resp, lat, rp, rp_next);
        check("t6 fresh rdata", d, 32'h01020304);
        check("t6 fresh rresp", resp, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=expired required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
- Synthesizable AXI4-lite responder: a register bank on the slave end of the AXI4-lite control bus used by the NTP server blocks.
- Exposes NUM_RW control registers to user logic as a flat vector.
- Returns NUM_RO status words sampled from user logic.
- Out-of-range and illegal accesses get error responses that the bus master flags through RESP[1].

Parameters:
- C_S_AXI_ADDR_WIDTH, 32, address width.
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported, ADDR_LSB=2.
- NUM_RW, 8, number of read/write control registers, word indices 0..NUM_RW-1.
- NUM_RO, 8, number of read-only status registers, word indices NUM_RW..NUM_RW+NUM_RO-1.
- RW_RESET_VAL, 32'h0, reset value applied to every RW register.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESET  in  1  synchronous active-high reset.
- S_AXI_AWADDR  in  ADDR  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  AW handshake.
- S_AXI_WDATA  in  DATA  write data.
- S_AXI_WSTRB  in  DATA/8  byte enables.
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  W handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  B handshake.
- S_AXI_ARADDR  in  ADDR  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  AR handshake.
- S_AXI_RDATA  out  DATA  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  R handshake.
- ctrl_o  out  NUM_RW*DATA  RW register contents; register i is at [i*32 +: 32].
- wr_pulse_o  out  NUM_RW  one-cycle strobe per committed write.
- status_i  in  NUM_RO*DATA  RO register sources.
- rd_pulse_o  out  NUM_RO  one-cycle strobe per RO read, for clear-on-read logic.

Behaviour:
- Clocking and reset: single clock, S_AXI_ACLK. Reset is synchronous and active-high on S_AXI_ARESET.
- Reset values:
  - BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0.
  - ctrl_o = RW_RESET_VAL per register.
  - wr_pulse_o=0, rd_pulse_o=0.
  - aw_held=0, w_held=0.
  - AWREADY, WREADY and ARREADY are 0 while S_AXI_ARESET=1.
- Address decode: idx = ADDR[ADDR_W-1:2]; ADDR[1:0] is ignored.
  - idx<NUM_RW: RW register.
  - NUM_RW<=idx<NUM_RW+NUM_RO: RO register.
  - Otherwise: out of range.
- Write channel (AW and W are accepted independently, in any order):
  - AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID.
  - On a handshake edge, latch ADDR into aw_held, or DATA/STRB into w_held.
  - Commit occurs on the first edge at which both aw_held and w_held are already set. Minimum latency: AW+W handshake at edge E, commit and BVALID=1 at edge E+1.
  - At commit:
    - RW target: byte-lane merge (lane b updated iff WSTRB[b]); wr_pulse_o[idx]=1 for exactly one cycle, even if WSTRB=0; BRESP=OKAY.
    - RO target: no state change; BRESP=SLVERR.
    - Out of range: no state change; BRESP=DECERR.
  - Both held flags clear at commit.
  - BVALID holds, with BRESP stable, until the BREADY edge. No new AW/W is accepted while BVALID=1.
- Read channel:
  - ARREADY = !RVALID.
  - On the AR handshake edge: RDATA/RRESP/RVALID are registered on that same edge (1-cycle latency).
    - RW: ctrl value before any same-edge write commit (old value), RRESP=OKAY.
    - RO: status_i sampled at that edge; rd_pulse_o[idx-NUM_RW]=1 for one cycle; RRESP=OKAY.
    - Out of range: RDATA=0, RRESP=DECERR.
  - RVALID and RDATA hold until the RREADY edge. Maximum throughput is one read per 2 cycles.
- Read and write channels are independent. A simultaneous read and commit to the same RW index returns the old value; the new value is visible to the next read.
- Reset mid-transaction: held AW/W and pending B/R are discarded, no response is issued, and registers return to their reset values.

Decomposition:
- Package axi_lite_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - ADDR_LSB=2.
  - Typedef axi_resp_t.
  - Function decode_idx() returning enum {REG_RW, REG_RO, REG_NONE}.
- One sub-module, axi_lite_wr_capture: independent AW/W holding registers, READY generation and commit strobe. Register bank and read path stay in the top module.

Test Plan (NUM_RW=4, NUM_RO=2; RW at 0x00-0x0C, RO at 0x10-0x14):
1. Write 0x0C=0xDEADBEEF with WSTRB=4'hF, AW and W in the same cycle -> BVALID one cycle after the handshake, BRESP=00; wr_pulse_o[3] for 1 cycle; read 0x0C returns 0xDEADBEEF, RRESP=00.
2. Preload 0x04=0x11223344, then write 0x04=0xAABBCCDD with WSTRB=4'b0101 -> readback 0x11BB33DD.
3. W presented 3 cycles before AW, with BREADY held low 2 cycles after BVALID -> AWREADY and WREADY stay low while BVALID=1, BRESP stable, single commit.
4. status_i word1=0x00C0FFEE, read 0x14 -> RDATA=0x00C0FFEE, rd_pulse_o[1]=1 for 1 cycle; write 0x10 -> BRESP=SLVERR, ctrl_o unchanged.
5. Read 0x18 -> RRESP=DECERR, RDATA=0; write 0x40 -> BRESP=DECERR.
6. Assert S_AXI_ARESET with AW held and W not yet sent -> BVALID never asserts, ctrl_o=RW_RESET_VAL; after reset, a fresh write to 0x00 completes normally.
